vram_arbiter: RTL
=================

// Module: vram_arbiter
// PURPOSE
//  Shares a single-port synchronous video RAM (framebuffer) between the VGA scan-out
//  pixel fetcher and the CPU load/store path. Runs on CLK50MHZ; the VGA fetcher
//  issues at most one read per two clocks during active video, so the CPU gets the
//  free slots. A starvation guard forces a CPU slot and flags a VGA underrun.
// PARAMETERS
//  ADDR_W    17  framebuffer word address width (320x240 = 76800 words)
//  DATA_W     8  pixel / data word width (RGB332)
//  MAX_WAIT   4  cycles a CPU request may be refused before it is forced through
// PORTS
//  CLK50MHZ      in   1       system clock; all logic on rising edge
//  RST           in   1       synchronous reset, active-high
//  vga_req       in   1       VGA fetch request, one cycle per pixel read
//  vga_addr      in   ADDR_W  VGA fetch address, valid with vga_req
//  vga_rvalid    out  1       one-cycle pulse: vga_rdata updated
//  vga_rdata     out  DATA_W  last pixel returned; holds between pulses
//  vga_underrun  out  1       sticky: a VGA request was dropped
//  underrun_clr  in   1       clears vga_underrun
//  cpu_req       in   1       CPU access request; held until cpu_gnt
//  cpu_we        in   1       1 = write, 0 = read; valid with cpu_req
//  cpu_addr      in   ADDR_W  CPU address
//  cpu_wdata     in   DATA_W  CPU write data
//  cpu_gnt       out  1       combinational accept; handshake = cpu_req & cpu_gnt
//  cpu_rvalid    out  1       one-cycle pulse: cpu_rdata valid (reads only)
//  cpu_rdata     out  DATA_W  CPU read data; holds between pulses
//  mem_en        out  1       RAM access enable (registered)
//  mem_we        out  1       RAM write enable (registered)
//  mem_addr      out  ADDR_W  RAM address (registered)
//  mem_wdata     out  DATA_W  RAM write data (registered)
//  mem_rdata     in   DATA_W  RAM read data, valid 1 cycle after mem_en & ~mem_we
// BEHAVIOUR
//  - Reset: every output reg 0 (mem_*, vga_rvalid/rdata, cpu_rvalid/rdata,
//    vga_underrun); wait_cnt = 0; all pipeline tags NONE. cpu_gnt = 0 while RST.
//  - Arbitration (cycle t, combinational): if cpu_req & wait_cnt==MAX_WAIT -> CPU;
//    else if vga_req -> VGA; else if cpu_req -> CPU; else idle.
//  - Winner registered into mem_* at edge ending t (visible t+1), tag S1 in
//    {NONE,VGA,CPU_RD,CPU_WR}. Idle: mem_en=0, mem_we=0, mem_addr/mem_wdata hold.
//  - Tag pipeline S1->S2 tracks RAM latency; at S2 (cycle t+2) mem_rdata is
//    captured: VGA -> vga_rdata, vga_rvalid=1 in t+3; CPU_RD -> cpu_rdata,
//    cpu_rvalid=1 in t+3. CPU_WR / NONE -> no pulse. Read latency = 3 cycles.
//  - Throughput: one access per cycle; back-to-back grants allowed.
//  - wait_cnt: +1 per cycle with cpu_req & ~cpu_gnt, saturates at MAX_WAIT;
//    -> 0 on CPU grant or when cpu_req low.
//  - Forced CPU slot with vga_req high: VGA request dropped (no vga_rvalid,
//    vga_rdata holds), vga_underrun <= 1. Set and underrun_clr same cycle: set wins.
//  - cpu_req dropped before grant: legal, no access; wait_cnt -> 0.
//  - CPU write then read same address in consecutive grants: read returns new data
//    (RAM order preserved, no reordering).
//  - RST mid-operation: in-flight tags cleared; returning mem_rdata discarded, no
//    rvalid pulses for pre-reset requests.
// TESTING
//  1 Assert RST 2 cycles with random inputs -> all outputs 0, cpu_gnt=0 throughout.
//  2 vga_req @c0 addr 0x00010, RAM holds 0xA5 -> c1 mem_en=1 mem_we=0 addr 0x10;
//    c3 vga_rvalid=1 vga_rdata=0xA5; vga_rdata still 0xA5 at c4.
//  3 c0 vga_req + cpu_req we=1 addr 0x20 wdata 0x3C; c1 vga_req=0 -> cpu_gnt c0=0,
//    c1=1; c2 mem_we=1 addr 0x20 wdata 0x3C; CPU read 0x20 next -> cpu_rdata=0x3C.
//  4 vga_req held high, cpu_req read from c0 -> cpu_gnt=0 c0..c3, =1 at c4;
//    vga_underrun=1 from c5; VGA req of c4 yields no vga_rvalid at c7.
//  5 vga_underrun=1, underrun_clr pulse with no forced slot -> 0 next cycle;
//    clr coincident with new forced slot -> stays 1.
//  6 CPU read granted c0, RST at c1 for 1 cycle -> no cpu_rvalid at c3; all outputs 0.

Source files
------------

// File: rtl/vram_arbiter.sv
// VRAM arbiter: shares one synchronous RAM port between VGA fetch and CPU.
// Two-stage tag pipeline routes read data back to the requester.
module vram_arbiter #(
  parameter int ADDR_W   = 17,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic              CLK50MHZ,
  input  logic              RST,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              vga_underrun,
  input  logic              underrun_clr,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    T_NONE,
    T_VGA,
    T_CPU_RD,
    T_CPU_WR
  } tag_t;

  logic [WW-1:0] wait_cnt;
  tag_t          s1_tag;
  tag_t          s2_tag;
  tag_t          tag_next;
  logic          forced;
  logic          sel_cpu;
  logic          sel_vga;
  logic          drop_vga;

  always_comb begin
    forced   = cpu_req && (wait_cnt == WW'(MAX_WAIT));
    sel_cpu  = !RST && cpu_req && (forced || !vga_req);
    sel_vga  = !RST && vga_req && !sel_cpu;
    drop_vga = !RST && forced && vga_req;
    tag_next = T_NONE;
    unique case (1'b1)
      sel_cpu: tag_next = cpu_we ? T_CPU_WR : T_CPU_RD;
      sel_vga: tag_next = T_VGA;
      default: tag_next = T_NONE;
    endcase
  end

  assign cpu_gnt = sel_cpu;

  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      s1_tag       <= T_NONE;
      s2_tag       <= T_NONE;
      vga_rvalid   <= 1'b0;
      vga_rdata    <= '0;
      cpu_rvalid   <= 1'b0;
      cpu_rdata    <= '0;
      vga_underrun <= 1'b0;
      wait_cnt     <= '0;
    end else begin
      mem_en <= sel_cpu || sel_vga;
      mem_we <= sel_cpu && cpu_we;
      if (sel_cpu) begin
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
      end else if (sel_vga) begin
        mem_addr  <= vga_addr;
      end
      s1_tag <= tag_next;
      s2_tag <= s1_tag;
      vga_rvalid <= (s2_tag == T_VGA);
      cpu_rvalid <= (s2_tag == T_CPU_RD);
      if (s2_tag == T_VGA) vga_rdata <= mem_rdata;
      if (s2_tag == T_CPU_RD) cpu_rdata <= mem_rdata;
      // A forced slot that steals a live VGA request wins over a clear
      if (drop_vga) vga_underrun <= 1'b1;
      else if (underrun_clr) vga_underrun <= 1'b0;
      if (!cpu_req || sel_cpu) wait_cnt <= '0;
      else if (wait_cnt < WW'(MAX_WAIT)) wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule
